// File: rtl/status_cond_unit_pkg.sv
// Shared definitions for the status register / condition unit and its
// reusable condition checker.
package status_cond_unit_pkg;

  localparam int unsigned STATUS_W = 4;
  localparam int unsigned COND_W   = 4;

  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

  localparam logic [COND_W-1:0] COND_EQ = 4'h0;
  localparam logic [COND_W-1:0] COND_NE = 4'h1;
  localparam logic [COND_W-1:0] COND_CS = 4'h2;
  localparam logic [COND_W-1:0] COND_CC = 4'h3;
  localparam logic [COND_W-1:0] COND_MI = 4'h4;
  localparam logic [COND_W-1:0] COND_PL = 4'h5;
  localparam logic [COND_W-1:0] COND_VS = 4'h6;
  localparam logic [COND_W-1:0] COND_VC = 4'h7;
  localparam logic [COND_W-1:0] COND_HI = 4'h8;
  localparam logic [COND_W-1:0] COND_LS = 4'h9;
  localparam logic [COND_W-1:0] COND_GE = 4'hA;
  localparam logic [COND_W-1:0] COND_LT = 4'hB;
  localparam logic [COND_W-1:0] COND_GT = 4'hC;
  localparam logic [COND_W-1:0] COND_LE = 4'hD;
  localparam logic [COND_W-1:0] COND_AL = 4'hE;
  localparam logic [COND_W-1:0] COND_NV = 4'hF;

endpackage

// File: rtl/status_cond_unit_cond_check.sv
// Pure combinational ARM condition-field evaluation against an NZCV vector.
// Shared with the branch unit, so it carries no state.
module cond_check
  import status_cond_unit_pkg::*;
(
  input  logic [COND_W-1:0]   i_cond,
  input  logic [STATUS_W-1:0] i_flags,
  output logic                o_pass_c
);

  logic w_n;
  logic w_z;
  logic w_c;
  logic w_v;

  assign w_n = i_flags[FLAG_N];
  assign w_z = i_flags[FLAG_Z];
  assign w_c = i_flags[FLAG_C];
  assign w_v = i_flags[FLAG_V];

  // Reserved code NV falls through to the default and never passes.
  always_comb begin
    o_pass_c = 1'b0;
    case (i_cond)
      COND_EQ: o_pass_c = w_z;
      COND_NE: o_pass_c = !w_z;
      COND_CS: o_pass_c = w_c;
      COND_CC: o_pass_c = !w_c;
      COND_MI: o_pass_c = w_n;
      COND_PL: o_pass_c = !w_n;
      COND_VS: o_pass_c = w_v;
      COND_VC: o_pass_c = !w_v;
      COND_HI: o_pass_c = w_c & !w_z;
      COND_LS: o_pass_c = !w_c | w_z;
      COND_GE: o_pass_c = (w_n == w_v);
      COND_LT: o_pass_c = (w_n != w_v);
      COND_GT: o_pass_c = !w_z & (w_n == w_v);
      COND_LE: o_pass_c = w_z | (w_n != w_v);
      COND_AL: o_pass_c = 1'b1;
      default: o_pass_c = 1'b0;
    endcase
  end

endmodule

// File: rtl/status_cond_unit.sv
// Architectural status register with EXE->ID flag forwarding and a one-entry
// valid/ready stage holding the condition decision for the ID/EXE boundary.
module status_cond_unit
  import status_cond_unit_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic [STATUS_W-1:0] statusIn,
  input  logic                exeSIn,
  input  logic                exeValidIn,
  input  logic [COND_W-1:0]   condIn,
  input  logic                idValidIn,
  output logic                idReadyOut,
  input  logic                flushIn,
  input  logic                downReadyIn,
  output logic                validOut,
  output logic                condPassOut,
  output logic [STATUS_W-1:0] statusOut,
  output logic                carryOut
);

  logic [STATUS_W-1:0] r_sr;
  logic                r_valid;
  logic                r_cond_pass;

  logic                w_sr_we;
  logic [STATUS_W-1:0] w_flags;
  logic                w_accept;
  logic                w_pass;

  // The EXE instruction is older than any flush source, so its flags commit regardless.
  assign w_sr_we = exeValidIn & exeSIn;
  assign w_flags = w_sr_we ? statusIn : r_sr;

  assign idReadyOut = !r_valid | downReadyIn;
  assign w_accept   = idValidIn & idReadyOut & !flushIn;

  cond_check u_cond_check (
    .i_cond   (condIn),
    .i_flags  (w_flags),
    .o_pass_c (w_pass)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sr <= '0;
    end else if (w_sr_we) begin
      r_sr <= statusIn;
    end
  end

  // Flush beats accept and hold; a held decision is never re-evaluated.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid     <= 1'b0;
      r_cond_pass <= 1'b0;
    end else if (flushIn) begin
      r_valid <= 1'b0;
    end else if (w_accept) begin
      r_valid     <= 1'b1;
      r_cond_pass <= w_pass;
    end else if (downReadyIn) begin
      r_valid <= 1'b0;
    end
  end

  assign validOut    = r_valid;
  assign condPassOut = r_cond_pass;
  assign statusOut   = r_sr;
  assign carryOut    = r_sr[FLAG_C];

endmodule

// File: tb/tb_status_cond_unit.sv
// Directed bench for status_cond_unit: vector table, full decode sweep and
// multi-cycle sequences for forwarding, backpressure, flush and async reset.
module tb_status_cond_unit;
  import status_cond_unit_pkg::*;

  logic       clk;
  logic       rst;
  logic [3:0] statusIn;
  logic       exeSIn;
  logic       exeValidIn;
  logic [3:0] condIn;
  logic       idValidIn;
  logic       idReadyOut;
  logic       flushIn;
  logic       downReadyIn;
  logic       validOut;
  logic       condPassOut;
  logic [3:0] statusOut;
  logic       carryOut;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [3:0] flags;
    logic [3:0] cond;
    logic       exp;
  } vec_t;

  localparam int unsigned NVEC = 19;
  vec_t vecs [NVEC];

  status_cond_unit dut (
    .clk         (clk),
    .rst         (rst),
    .statusIn    (statusIn),
    .exeSIn      (exeSIn),
    .exeValidIn  (exeValidIn),
    .condIn      (condIn),
    .idValidIn   (idValidIn),
    .idReadyOut  (idReadyOut),
    .flushIn     (flushIn),
    .downReadyIn (downReadyIn),
    .validOut    (validOut),
    .condPassOut (condPassOut),
    .statusOut   (statusOut),
    .carryOut    (carryOut)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk1(input string name, input logic got, input logic exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%b exp=%b t=%0t", name, got, exp, $time);
    end
  endtask

  task automatic chk4(input string name, input logic [3:0] got, input logic [3:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%b exp=%b t=%0t", name, got, exp, $time);
    end
  endtask

  // Pairwise ARM formulation: even code gives the base test, odd code inverts it.
  function automatic logic ref_pass(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v, base;
    n  = f[3];
    z  = f[2];
    cy = f[1];
    v  = f[0];
    case (c[3:1])
      3'd0:    base = z;
      3'd1:    base = cy;
      3'd2:    base = n;
      3'd3:    base = v;
      3'd4:    base = cy && !z;
      3'd5:    base = (n == v);
      3'd6:    base = !z && (n == v);
      default: base = 1'b1;
    endcase
    return base ^ c[0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_sr(input logic [3:0] f);
    exeValidIn = 1'b1;
    exeSIn     = 1'b1;
    statusIn   = f;
    idValidIn  = 1'b0;
    tick();
    exeValidIn = 1'b0;
    exeSIn     = 1'b0;
  endtask

  initial begin
    vecs[0]  = '{4'b0100, COND_EQ, 1'b1};
    vecs[1]  = '{4'b0000, COND_NE, 1'b1};
    vecs[2]  = '{4'b0010, COND_CS, 1'b1};
    vecs[3]  = '{4'b0010, COND_CC, 1'b0};
    vecs[4]  = '{4'b1000, COND_MI, 1'b1};
    vecs[5]  = '{4'b1000, COND_PL, 1'b0};
    vecs[6]  = '{4'b0001, COND_VS, 1'b1};
    vecs[7]  = '{4'b0001, COND_VC, 1'b0};
    vecs[8]  = '{4'b0010, COND_HI, 1'b1};
    vecs[9]  = '{4'b0110, COND_HI, 1'b0};
    vecs[10] = '{4'b0110, COND_LS, 1'b1};
    vecs[11] = '{4'b1001, COND_GE, 1'b1};
    vecs[12] = '{4'b1000, COND_LT, 1'b1};
    vecs[13] = '{4'b0000, COND_GT, 1'b1};
    vecs[14] = '{4'b0100, COND_GT, 1'b0};
    vecs[15] = '{4'b1000, COND_LE, 1'b1};
    vecs[16] = '{4'b0000, COND_LE, 1'b0};
    vecs[17] = '{4'b0000, COND_AL, 1'b1};
    vecs[18] = '{4'b1111, COND_NV, 1'b0};

    rst         = 1'b0;
    statusIn    = 4'b0000;
    exeSIn      = 1'b0;
    exeValidIn  = 1'b0;
    condIn      = COND_EQ;
    idValidIn   = 1'b0;
    flushIn     = 1'b0;
    downReadyIn = 1'b1;

    #12;
    chk4("rst_status", statusOut, 4'b0000);
    chk1("rst_valid", validOut, 1'b0);
    chk1("rst_pass", condPassOut, 1'b0);
    chk1("rst_carry", carryOut, 1'b0);
    chk1("rst_ready", idReadyOut, 1'b1);
    tick();
    rst = 1'b1;
    tick();

    // SR write, then a non-flag-setting EXE instruction leaves SR alone
    load_sr(4'b0110);
    chk4("sr_write", statusOut, 4'b0110);
    chk1("sr_carry", carryOut, 1'b1);
    exeValidIn = 1'b1;
    exeSIn     = 1'b0;
    statusIn   = 4'b1001;
    tick();
    exeValidIn = 1'b0;
    chk4("sr_hold_nos", statusOut, 4'b0110);

    // Forwarding: flags written this cycle are seen by the ID condition
    load_sr(4'b0000);
    exeValidIn = 1'b1;
    exeSIn     = 1'b1;
    statusIn   = 4'b0100;
    condIn     = COND_EQ;
    idValidIn  = 1'b1;
    tick();
    chk1("fwd_valid", validOut, 1'b1);
    chk1("fwd_pass", condPassOut, 1'b1);
    load_sr(4'b0000);
    exeValidIn = 1'b1;
    exeSIn     = 1'b0;
    statusIn   = 4'b0100;
    condIn     = COND_EQ;
    idValidIn  = 1'b1;
    tick();
    exeValidIn = 1'b0;
    chk1("nofwd_valid", validOut, 1'b1);
    chk1("nofwd_pass", condPassOut, 1'b0);
    chk4("nofwd_sr", statusOut, 4'b0000);

    // Hand-computed vector table
    for (int i = 0; i < int'(NVEC); i++) begin
      load_sr(vecs[i].flags);
      condIn    = vecs[i].cond;
      idValidIn = 1'b1;
      tick();
      idValidIn = 1'b0;
      chk1($sformatf("vec%0d_valid", i), validOut, 1'b1);
      chk1($sformatf("vec%0d_pass", i), condPassOut, vecs[i].exp);
    end

    // Full sweep: every flag value against every condition code
    for (int f = 0; f < 16; f++) begin
      load_sr(4'(f));
      for (int c = 0; c < 16; c++) begin
        condIn    = 4'(c);
        idValidIn = 1'b1;
        tick();
        chk1($sformatf("sweep_f%0h_c%0h_pass", f, c), condPassOut, ref_pass(4'(c), 4'(f)));
      end
      idValidIn = 1'b0;
    end
    tick();
    chk1("sweep_drained", validOut, 1'b0);

    // Backpressure: A held while B waits and SR keeps changing
    load_sr(4'b0100);
    downReadyIn = 1'b0;
    condIn      = COND_EQ;
    idValidIn   = 1'b1;
    tick();
    chk1("bp_a_valid", validOut, 1'b1);
    chk1("bp_a_pass", condPassOut, 1'b1);
    for (int k = 0; k < 3; k++) begin
      exeValidIn = 1'b1;
      exeSIn     = 1'b1;
      statusIn   = (k == 1) ? 4'b1000 : 4'b0000;
      tick();
      chk1($sformatf("bp_hold%0d_valid", k), validOut, 1'b1);
      chk1($sformatf("bp_hold%0d_pass", k), condPassOut, 1'b1);
      chk1($sformatf("bp_hold%0d_ready", k), idReadyOut, 1'b0);
    end
    exeValidIn  = 1'b0;
    exeSIn      = 1'b0;
    downReadyIn = 1'b1;
    #1;
    chk1("bp_release_ready", idReadyOut, 1'b1);
    tick();
    chk1("bp_b_valid", validOut, 1'b1);
    chk1("bp_b_pass", condPassOut, 1'b0);
    idValidIn = 1'b0;
    tick();
    chk1("bp_drain", validOut, 1'b0);

    // Flush beats a simultaneous accept; SR still commits
    condIn    = COND_AL;
    idValidIn = 1'b1;
    tick();
    chk1("fl_pre_valid", validOut, 1'b1);
    chk1("fl_pre_ready", idReadyOut, 1'b1);
    flushIn    = 1'b1;
    exeValidIn = 1'b1;
    exeSIn     = 1'b1;
    statusIn   = 4'b1001;
    tick();
    flushIn    = 1'b0;
    exeValidIn = 1'b0;
    exeSIn     = 1'b0;
    idValidIn  = 1'b0;
    chk1("fl_valid", validOut, 1'b0);
    chk4("fl_status", statusOut, 4'b1001);

    // Async reset in the middle of a stall
    downReadyIn = 1'b0;
    exeValidIn  = 1'b1;
    exeSIn      = 1'b1;
    statusIn    = 4'b1111;
    condIn      = COND_AL;
    idValidIn   = 1'b1;
    tick();
    exeValidIn = 1'b0;
    exeSIn     = 1'b0;
    idValidIn  = 1'b0;
    tick();
    chk1("ar_pre_valid", validOut, 1'b1);
    chk4("ar_pre_status", statusOut, 4'b1111);
    #2;
    rst = 1'b0;
    #1;
    chk1("ar_valid", validOut, 1'b0);
    chk4("ar_status", statusOut, 4'b0000);
    chk1("ar_carry", carryOut, 1'b0);
    chk1("ar_ready", idReadyOut, 1'b1);
    tick();
    rst = 1'b1;
    downReadyIn = 1'b1;
    tick();
    chk1("ar_after_valid", validOut, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/status_cond_unit.md
Name: status_cond_unit

Overview:
- Consumer end of the ALU status interface: captures the NZCV flags produced in EXE into the architectural status register (SR).
- Returns the SR carry to the ALU.
- Evaluates the 4-bit ARM condition field of the instruction leaving ID against forwarded flags.
- Registers the pass/fail decision into a one-entry valid/ready output stage that feeds the ID/EXE boundary.

Parameters:
- STATUS_W, 4, flag vector width, ordered {N,Z,C,V} (bit3..bit0); fixed at 4, present for readability only.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  reset, asynchronous, active-low: 0 resets, 1 runs.
- statusIn  in  4  {N,Z,C,V} from ALU of the instruction currently in EXE.
- exeSIn  in  1  EXE instruction has S bit set.
- exeValidIn  in  1  EXE holds a live, condition-passed instruction.
- condIn  in  4  condition field of the ID-stage instruction.
- idValidIn  in  1  ID offers an instruction.
- idReadyOut  out  1  unit can accept from ID this cycle.
- flushIn  in  1  branch-taken flush of younger stages.
- downReadyIn  in  1  ID/EXE stage accepts the registered decision.
- validOut  out  1  registered decision is valid.
- condPassOut  out  1  registered condition result.
- statusOut  out  4  architectural SR.
- carryOut  out  1  SR carry (statusOut[1]) to the ALU carry input.

Behaviour:
- Reset (rst=0, asynchronous): SR=4'b0000, validOut=0, condPassOut=0; statusOut=0, carryOut=0. idReadyOut=1 once the output stage is empty.
- SR update: on each rising edge, SR<=statusIn when exeValidIn&exeSIn; otherwise SR holds.
  - Not gated by flushIn: the EXE instruction is older than the flush source and commits.
- Forwarded flags F (combinational): F=statusIn when exeValidIn&exeSIn, else F=SR.
  - Result: a flag-setting instruction immediately followed by a conditional one needs no stall.
- Condition decode on F, value 1 = pass:
  - 0 EQ Z; 1 NE !Z; 2 CS C; 3 CC !C; 4 MI N; 5 PL !N; 6 VS V; 7 VC !V.
  - 8 HI C&!Z; 9 LS !C|Z; A GE N==V; B LT N!=V.
  - C GT !Z&(N==V); D LE Z|(N!=V); E AL 1; F reserved -> 0.
- Output stage (one entry):
  - idReadyOut = !validOut | downReadyIn (combinational, no dependence on idValidIn).
  - Accept = idValidIn & idReadyOut & !flushIn; on accept, validOut<=1 and condPassOut<=decode(condIn,F). Latency: one cycle from accept to validOut.
  - Drain: validOut & downReadyIn and no accept -> validOut<=0. condPassOut holds its last value, don't-care when validOut=0.
  - Simultaneous drain and accept -> new entry loaded, validOut stays 1.
  - Stall: validOut & !downReadyIn -> entry and condPassOut held stable; idReadyOut=0. The held decision is not re-evaluated even if SR changes meanwhile (it was sampled at accept).
  - flushIn=1: validOut<=0 next edge, overriding both accept and hold. SR is still updated per its rule.
- Reset mid-operation clears SR and any pending entry immediately, without waiting for an edge.
- No arithmetic; all logic is width-exact, with no sign or zero extension.

Decomposition:
- Shared package holds:
  - condition-code constants COND_EQ..COND_NV (4'h0..4'hF);
  - flag index constants FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0;
  - STATUS_W.
- One natural sub-module: cond_check, a pure combinational mapping of (condIn, flags) to pass.
  - It is reusable by the branch unit.
  - The SR, forwarding mux and output stage stay in status_cond_unit.

Test Plan:
- Reset/SR write: rst=0 -> statusOut=0, validOut=0. Release rst, then exeValidIn=1, exeSIn=1, statusIn=4'b0110 for one cycle -> statusOut=4'b0110, carryOut=1 next cycle. Repeat with exeSIn=0 -> SR unchanged.
- Forwarding: SR=4'b0000, same cycle exeValidIn=exeSIn=1, statusIn=4'b0100, condIn=EQ, idValidIn=1 -> next cycle validOut=1, condPassOut=1. Same stimulus with exeSIn=0 -> condPassOut=0.
- Full decode sweep: for each of the 16 flag values × 16 conditions with SR preloaded, compare condPassOut against the table. Include:
  - GE with N=1, V=1 -> 1;
  - LE with Z=0, N=1, V=0 -> 1;
  - code F -> 0 always.
- Backpressure: accept entry A (pass=1), hold downReadyIn=0 for 3 cycles while offering B and changing SR -> validOut=1, condPassOut=1 stable, idReadyOut=0. Raise downReadyIn -> same cycle idReadyOut=1, B loads next edge.
- Flush priority: validOut=1, idValidIn=1, idReadyOut=1, flushIn=1, and EXE writes statusIn=4'b1001 -> next cycle validOut=0, statusOut=4'b1001.
- Async reset mid-stall: validOut=1, SR=4'b1111, drop rst between edges -> validOut=0 and statusOut=0 before the next clock edge.
